mul2_low_speed: RTL and testbench
=================================

MUL2_LOW_SPEED -- requirements
Module: mul2_low_speed

Interface
REQ-001 Parameter DW, default 4, operand width in bits.
REQ-002 Parameter OW, default 2*DW+1 (9), result width in bits; fixed by DW and not overridden.
REQ-003 clk  input  1  single clock (low-speed domain, nominal 100 MHz).
REQ-004 rstn  input  1  reset; one clock, asynchronous, active-low.
REQ-005 en  input  1  operand-valid qualifier, sampled on rising clk.
REQ-006 mul1  input  DW  unsigned operand A of product 0.
REQ-007 mul2  input  DW  unsigned operand B of product 0.
REQ-008 mul3  input  DW  unsigned operand A of product 1.
REQ-009 mul4  input  DW  unsigned operand B of product 1.
REQ-010 dout  output  OW  registered result mul1*mul2 + mul3*mul4.
REQ-011 dout_en  output  1  registered valid flag for dout.

Function
REQ-012 All arithmetic unsigned; each product 2*DW bits, sum OW bits, no overflow possible (max 2*15*15=450 < 512).
REQ-013 Stage 1: on a rising clk with en=1, register p0=mul1*mul2, p1=mul3*mul4 and v1=1; with en=0, v1=0 and p0/p1 hold.
REQ-014 Stage 2: on every rising clk, dout_en <= v1; when v1=1, dout <= p0+p1; when v1=0, dout holds its last value.
REQ-015 Latency: exactly 2 clk cycles from the sampling edge to dout/dout_en valid; throughput one result per cycle with en held high.
REQ-016 dout_en is a per-result pulse: high for exactly as many consecutive cycles as en was high, delayed 2 cycles.
REQ-017 No backpressure; results are never stalled or dropped.
REQ-018 Operand changes while en=0 have no effect on dout (operand-isolation for low power).

Reset
REQ-019 rstn=0 asynchronously clears p0, p1, v1, dout (0) and dout_en (0), independent of clk.
REQ-020 Reset asserted mid-operation discards all in-flight results; after release, first dout_en no earlier than 2 cycles after the first en=1 sample.
REQ-021 Reset release is synchronous to clk by the integrator; the block has no internal synchronizer.

Structure
REQ-022 DW, OW and the product width 2*DW are defined as constants in a shared package low_power_mul_pkg, also used by the high-speed variant.
REQ-023 One sub-module mul_stage (registered DW x DW unsigned multiplier with en gating), instantiated twice for p0 and p1; adder and output register at top level.
REQ-024 The companion block mul1_hs (same ports minus mul3/mul4, 200 MHz) reuses mul_stage once and accumulates two consecutive en-qualified products into one OW result with a dout_en pulse per pair, giving the same throughput per operand pair.

Verification
REQ-025 Reset: rstn=0 for 8 ns, then release with en=0 -> dout=0, dout_en=0 for all cycles.
REQ-026 Single op: en=1 one cycle, (1,15,2,14) -> 2 cycles later dout=43, dout_en=1 for one cycle, dout holds 43 afterwards.
REQ-027 Stream: en=1 for 6 cycles with (1,15,2,14),(3,13,4,12),(5,11,6,10),(7,9,8,8),(9,7,10,6),(11,5,12,4) -> dout 43,87,115,127,123,103 on consecutive cycles, dout_en high 6 cycles.
REQ-028 Max value: (15,15,15,15) -> dout=450; zero operands (0,15,0,15) -> dout=0 with dout_en=1.
REQ-029 Isolation: en=0 while operands toggle randomly -> dout unchanged, dout_en=0.
REQ-030 Mid-reset: assert rstn=0 one cycle after en=1 -> dout=0, dout_en=0 immediately; no stale result after release.

Source files
------------

// File: rtl/low_power_mul_pkg.sv
// Shared constants for the low-power multiply-add blocks (low-speed and high-speed variants).
package low_power_mul_pkg;

    localparam int unsigned MulDw = 4;             // operand width
    localparam int unsigned MulPw = 2 * MulDw;     // single product width
    localparam int unsigned MulOw = 2 * MulDw + 1; // sum of two products, cannot overflow

endpackage

// File: rtl/mul_stage.sv
// Registered unsigned DW x DW multiplier. Operands are only captured when en_i is high,
// so the product register and downstream logic stay quiet while en_i is low.
module mul_stage #(
    parameter int unsigned DW = 4,
    localparam int unsigned PW = 2 * DW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [PW-1:0] p_o,
    output logic          valid_o
);

    logic [PW-1:0] p_d, p_q;
    logic          valid_d, valid_q;

    always_comb begin
        p_d     = p_q;
        valid_d = en_i;
        if (en_i) begin
            p_d = PW'(a_i) * PW'(b_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            p_q     <= p_d;
            valid_q <= valid_d;
        end
    end

    assign p_o     = p_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/mul2_low_speed.sv
// Two-stage multiply-add: dout = mul1*mul2 + mul3*mul4, one result per en-qualified cycle.
module mul2_low_speed
    import low_power_mul_pkg::*;
#(
    parameter int unsigned DW = MulDw,
    localparam int unsigned PW = 2 * DW,
    localparam int unsigned OW = 2 * DW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic [DW-1:0] mul1,
    input  logic [DW-1:0] mul2,
    input  logic [DW-1:0] mul3,
    input  logic [DW-1:0] mul4,
    output logic [OW-1:0] dout,
    output logic          dout_en
);

    logic [PW-1:0] p0, p1;
    logic          v0, v1;
    logic [OW-1:0] dout_d, dout_q;
    logic          dout_en_d, dout_en_q;

    mul_stage #(
        .DW(DW)
    ) u_mul_p0 (
        .clk_i  (clk),
        .rst_ni (rstn),
        .en_i   (en),
        .a_i    (mul1),
        .b_i    (mul2),
        .p_o    (p0),
        .valid_o(v0)
    );

    mul_stage #(
        .DW(DW)
    ) u_mul_p1 (
        .clk_i  (clk),
        .rst_ni (rstn),
        .en_i   (en),
        .a_i    (mul3),
        .b_i    (mul4),
        .p_o    (p1),
        .valid_o(v1)
    );

    // Both stages share en and reset, so their valids always agree.
    always_comb begin
        dout_en_d = v0 & v1;
        dout_d    = dout_q;
        if (dout_en_d) begin
            dout_d = OW'(p0) + OW'(p1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_q    <= '0;
            dout_en_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            dout_en_q <= dout_en_d;
        end
    end

    assign dout    = dout_q;
    assign dout_en = dout_en_q;

endmodule

// File: tb/tb_mul2_low_speed.sv
// Bench for mul2_low_speed: directed vectors plus random traffic against a queue-based model.
module tb_mul2_low_speed;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [3:0] mul1, mul2, mul3, mul4;
    logic [8:0] dout;
    logic       dout_en;

    int n_total;
    int n_bad;

    // Model: one entry per sampled cycle, -1 for an idle cycle.
    int pipe_q[$];
    int exp_dout;
    int exp_en;

    mul2_low_speed dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .mul1   (mul1),
        .mul2   (mul2),
        .mul3   (mul3),
        .mul4   (mul4),
        .dout   (dout),
        .dout_en(dout_en)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pipe_q.delete();
        exp_dout = 0;
        exp_en   = 0;
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at the falling edge.
    task automatic step(input logic e, input int a, input int b, input int c, input int d);
        int r;
        en   = e;
        mul1 = a[3:0];
        mul2 = b[3:0];
        mul3 = c[3:0];
        mul4 = d[3:0];
        @(posedge clk);
        exp_en = 0;
        if (pipe_q.size() > 0) begin
            r = pipe_q.pop_front();
            if (r >= 0) begin
                exp_dout = r;
                exp_en   = 1;
            end
        end
        pipe_q.push_back(e ? (a * b + c * d) : -1);
        @(negedge clk);
        check_eq("dout", dout, exp_dout);
        check_eq("dout_en", dout_en, exp_en);
    endtask

    int stream_ops[6][4] = '{
        '{1, 15, 2, 14}, '{3, 13, 4, 12}, '{5, 11, 6, 10},
        '{7, 9, 8, 8},   '{9, 7, 10, 6},  '{11, 5, 12, 4}
    };
    int stream_res[6] = '{43, 87, 115, 127, 123, 103};

    initial begin
        n_total = 0;
        n_bad   = 0;
        model_reset();
        rstn = 1'b0;
        en   = 1'b0;
        mul1 = '0;
        mul2 = '0;
        mul3 = '0;
        mul4 = '0;

        // Reset held 8 ns, then idle cycles
        #8;
        check_eq("rst_dout", dout, 0);
        check_eq("rst_dout_en", dout_en, 0);
        rstn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 0, 0);
        check_eq("idle_dout", dout, 0);

        // Single operation, then hold
        step(1'b1, 1, 15, 2, 14);
        check_eq("single_lat_en", dout_en, 0);
        step(1'b0, 0, 0, 0, 0);
        check_eq("single_dout", dout, 43);
        check_eq("single_en", dout_en, 1);
        for (int i = 0; i < 3; i++) step(1'b0, 3, 3, 3, 3);
        check_eq("single_hold", dout, 43);
        check_eq("single_pulse", dout_en, 0);

        // Six-cycle stream
        for (int i = 0; i < 7; i++) begin
            if (i < 6) step(1'b1, stream_ops[i][0], stream_ops[i][1], stream_ops[i][2],
                            stream_ops[i][3]);
            else step(1'b0, 0, 0, 0, 0);
            if (i >= 1) begin
                check_eq("stream_dout", dout, stream_res[i-1]);
                check_eq("stream_en", dout_en, 1);
            end
        end
        step(1'b0, 0, 0, 0, 0);
        check_eq("stream_end_en", dout_en, 0);

        // Max value and zero operands
        step(1'b1, 15, 15, 15, 15);
        step(1'b1, 0, 15, 0, 15);
        check_eq("max_dout", dout, 450);
        step(1'b0, 0, 0, 0, 0);
        check_eq("zero_dout", dout, 0);
        check_eq("zero_en", dout_en, 1);

        // Operand isolation while en is low
        step(1'b1, 9, 9, 3, 5);
        step(1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            step(1'b0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15));
        check_eq("iso_dout", dout, 96);
        check_eq("iso_en", dout_en, 0);

        // Mid-operation reset with one result out and one in flight
        step(1'b1, 2, 3, 4, 5);
        step(1'b1, 7, 7, 7, 7);
        rstn = 1'b0;
        #1;
        check_eq("midrst_dout", dout, 0);
        check_eq("midrst_en", dout_en, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 0);
        check_eq("post_rst_dout", dout, 0);
        step(1'b1, 1, 1, 1, 1);
        check_eq("post_rst_early", dout_en, 0);
        step(1'b0, 0, 0, 0, 0);
        check_eq("post_rst_dout2", dout, 2);

        // Random traffic
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
        step(1'b0, 0, 0, 0, 0);
        step(1'b0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
